magnetron_ctrl: RTL and testbench
=================================

Name: magnetron_ctrl

Overview:
Synchronous control stage directly upstream of the magnetron SR latch; it generates the latch's s (set, magnetron on) and r (reset, magnetron off) drive signals. It debounces the start, stop and clear panel buttons, watches the door and the cook-timer-done flag, and runs an IDLE/COOKING/PAUSED state machine. s and r are never asserted together.

Parameters:
DEB_CYCLES, 4, consecutive synchronized samples a button must hold a new level before its debounced value changes (>=1)
PULSE_LEN, 2, cycles s or r is held high per event (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
startn  input  1  start button, active-low, asynchronous, bouncy
stopn  input  1  stop/pause button, active-low, asynchronous, bouncy
clearn  input  1  clear/cancel button, active-low, asynchronous, bouncy
door_closed  input  1  1 = door closed; asynchronous, not debounced
timer_done  input  1  synchronous level from cook timer, 1 = time is zero
s  output  1  latch set drive, registered
r  output  1  latch reset drive, registered
state  output  2  00 IDLE, 01 COOKING, 10 PAUSED; 11 unused

Behaviour:
- Reset: async assert forces state=IDLE, s=0, r=1, button debounced levels=1 (released), debounce counters=0, door sync flops=0 (open). After rst_n deasserts, r stays 1 for PULSE_LEN edges, then follows the normal rules.
- Buttons: 2-flop synchronizer, then a counter. The debounced level changes when the synchronized value differs from it for DEB_CYCLES consecutive edges. The counter clears on any sample equal to the debounced level. A press event is a single-cycle pulse when the debounced level goes 1->0. Release generates no event.
- Latency: press events register in the FSM on the next edge. s or r rises exactly DEB_CYCLES+3 edges after the first edge that samples the button low, provided it stays low.
- door_closed: 2-flop synchronizer only (dclosed). No debounce, so it is the fastest path.
- Safety override: while dclosed=0, s=0 and r=1 continuously in every state, regardless of pulses. No set event is accepted.
- Set condition (go): start press AND dclosed AND NOT timer_done.
- IDLE: go -> COOKING and issue s pulse. Other events are ignored.
- COOKING, checked in priority order:
  - clear press -> IDLE
  - timer_done -> IDLE
  - dclosed=0 -> PAUSED
  - stop press -> PAUSED
  - Each of these issues an r pulse. A start press alone is ignored.
- PAUSED:
  - clear press or timer_done -> IDLE, issue r pulse.
  - go -> COOKING, issue s pulse. Clear and timer_done win over go.
  - stop press is ignored.
- Pulses: the issuing edge sets the output to 1 and loads a pulse counter with PULSE_LEN. The output drops after PULSE_LEN cycles.
  - A new r event during an s pulse: s=0 and r=1 on the same edge, fresh count.
  - An s event during an r pulse: r=0 and s=1, fresh count (only possible once the door is closed).
  - A same-type event restarts the count.
- Invariant: s & r == 0 on every cycle, including during reset.
- state=11 is unreachable. If it is ever entered, go to IDLE with an r pulse.
- Reset mid-pulse or mid-debounce: all progress is discarded. Reset values apply immediately and asynchronously.

Test Plan:
- Reset then door closed, DEB_CYCLES=4, PULSE_LEN=2: r=1 during reset and for 2 edges after release. Hold startn low: s=1 exactly 7 edges after first low sample, s high 2 cycles, state=01.
- Bounce: toggle startn every cycle for 3 cycles, then hold high -> no press event, s stays 0, state=00. A subsequent clean press of 4+ cycles gives the set pulse.
- Cooking, then door_closed falls -> r=1 within 2 edges, s=0, state=10, r held while open. Close the door and press start -> s pulse, state=01.
- Cooking, assert timer_done and clearn together -> state=00, one r pulse of 2 cycles. A start press while timer_done=1 gives no s.
- Press stop during an active s pulse (PULSE_LEN=4) -> s drops and r rises on the same edge, never both 1 (checked by assertion every cycle).
- Assert rst_n=0 mid-cooking during an s pulse -> s=0, r=1, state=00 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/magnetron_ctrl.sv
// Control stage ahead of the magnetron SR latch: debounces the panel buttons,
// synchronizes the door switch and sequences IDLE/COOKING/PAUSED into s/r pulses.
module magnetron_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int PULSE_LEN  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic       s,
  output logic       r,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_RESET  = PW'(PULSE_LEN);
  localparam logic [PW-1:0] PULSE_RELOAD = PW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COOKING = 2'b01,
    PAUSED  = 2'b10,
    BAD     = 2'b11
  } state_t;

  logic [2:0]    btn_raw, btn_s1, btn_s2, btn_deb, btn_deb_d, press;
  logic [DW-1:0] deb_cnt [3];
  logic          door_s1, dclosed;
  logic          start_p, stop_p, clear_p, go;
  state_t        cur, nxt;
  logic          set_evt, rst_evt;
  logic          s_n, r_p, r_p_n;
  logic [PW-1:0] cnt, cnt_n;

  assign btn_raw = {clearn, stopn, startn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1  <= '1;
      btn_s2  <= '1;
      door_s1 <= 1'b0;
      dclosed <= 1'b0;
    end else begin
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
      door_s1 <= door_closed;
      dclosed <= door_s1;
    end
  end

  // Level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_deb   <= '1;
      btn_deb_d <= '1;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      btn_deb_d <= btn_deb;
      for (int i = 0; i < 3; i++) begin
        if (btn_s2[i] == btn_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          btn_deb[i] <= btn_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press   = btn_deb_d & ~btn_deb;
  assign start_p = press[0];
  assign stop_p  = press[1];
  assign clear_p = press[2];
  assign go      = start_p & dclosed & ~timer_done;

  always_comb begin
    nxt     = cur;
    set_evt = 1'b0;
    rst_evt = 1'b0;
    case (cur)
      IDLE: begin
        if (go) begin
          nxt     = COOKING;
          set_evt = 1'b1;
        end
      end
      COOKING: begin
        if (clear_p || timer_done) begin
          nxt     = IDLE;
          rst_evt = 1'b1;
        end else if (!dclosed || stop_p) begin
          nxt     = PAUSED;
          rst_evt = 1'b1;
        end
      end
      PAUSED: begin
        if (clear_p || timer_done) begin
          nxt     = IDLE;
          rst_evt = 1'b1;
        end else if (go) begin
          nxt     = COOKING;
          set_evt = 1'b1;
        end
      end
      default: begin
        nxt     = IDLE;
        rst_evt = 1'b1;
      end
    endcase
  end

  // door_s1 is the dclosed value taking effect on this edge, so the
  // door override lines up exactly with dclosed=0.
  always_comb begin
    s_n   = s;
    r_p_n = r_p;
    cnt_n = cnt;
    if (rst_evt) begin
      s_n   = 1'b0;
      r_p_n = 1'b1;
      cnt_n = PULSE_RELOAD;
    end else if (set_evt) begin
      s_n   = 1'b1;
      r_p_n = 1'b0;
      cnt_n = PULSE_RELOAD;
    end else if (cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else begin
      s_n   = 1'b0;
      r_p_n = 1'b0;
    end
    if (!door_s1) s_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= IDLE;
      s   <= 1'b0;
      r   <= 1'b1;
      r_p <= 1'b1;
      cnt <= PULSE_RESET;
    end else begin
      cur <= nxt;
      s   <= s_n;
      r_p <= r_p_n;
      r   <= r_p_n | ~door_s1;
      cnt <= cnt_n;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Bench for magnetron_ctrl: two instances (PULSE_LEN 2 and 4) share stimulus,
// each tracked by a cycle model built from the control rules.
module tb_magnetron_ctrl;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n, startn, stopn, clearn, door_closed, timer_done;
  bit   chk_en;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {1'b0, act}, {1'b0, exp});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int P = (g == 0) ? 2 : 4;
    logic       s_o, r_o;
    logic [1:0] st_o;

    magnetron_ctrl #(.DEB_CYCLES(DEB), .PULSE_LEN(P)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .startn      (startn),
      .stopn       (stopn),
      .clearn      (clearn),
      .door_closed (door_closed),
      .timer_done  (timer_done),
      .s           (s_o),
      .r           (r_o),
      .state       (st_o)
    );

    // Model: inputs reach the control logic two edges late; presses act one
    // edge after the debounced level falls; pulses count remaining cycles.
    bit [3:0] dly_q[$];
    bit [2:0] lvl, pend;
    int       run[3];
    int       m_state, s_left, r_left;
    bit       m_s, m_r;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_q   = '{4'b0111, 4'b0111};
        lvl     = 3'b111;
        pend    = 3'b000;
        run     = '{0, 0, 0};
        m_state = 0;
        s_left  = 0;
        r_left  = P + 1;
        m_s     = 1'b0;
        m_r     = 1'b1;
      end else begin
        bit [3:0] seen, nxt;
        bit       go, set_e, rst_e;
        bit [2:0] fell;
        seen = dly_q.pop_front();
        nxt  = dly_q[0];
        dly_q.push_back({door_closed, clearn, stopn, startn});
        go    = pend[0] && seen[3] && !timer_done;
        set_e = 1'b0;
        rst_e = 1'b0;
        if (m_state == 0) begin
          if (go) begin m_state = 1; set_e = 1'b1; end
        end else if (m_state == 1) begin
          if (pend[2] || timer_done) begin m_state = 0; rst_e = 1'b1; end
          else if (!seen[3] || pend[1]) begin m_state = 2; rst_e = 1'b1; end
        end else begin
          if (pend[2] || timer_done) begin m_state = 0; rst_e = 1'b1; end
          else if (go) begin m_state = 1; set_e = 1'b1; end
        end
        fell = 3'b000;
        for (int b = 0; b < 3; b++) begin
          if (seen[b] != lvl[b]) begin
            run[b]++;
            if (run[b] == DEB) begin
              lvl[b]  = seen[b];
              run[b]  = 0;
              fell[b] = !seen[b];
            end
          end else begin
            run[b] = 0;
          end
        end
        pend = fell;
        if (rst_e) begin
          r_left = P;
          s_left = 0;
        end else if (set_e) begin
          s_left = P;
          r_left = 0;
        end else begin
          if (s_left > 0) s_left--;
          if (r_left > 0) r_left--;
        end
        if (!nxt[3]) s_left = 0;
        m_s = (s_left > 0);
        m_r = (r_left > 0) || !nxt[3];
      end
    end

    always @(posedge clk) begin
      #2;
      if (chk_en) begin
        chk1($sformatf("s_p%0d", P), s_o, m_s);
        chk1($sformatf("r_p%0d", P), r_o, m_r);
        check($sformatf("state_p%0d", P), st_o, m_state[1:0]);
        chk1($sformatf("s_and_r_p%0d", P), s_o & r_o, 1'b0);
      end
    end
  end

  initial begin
    rst_n = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; timer_done = 1'b0; chk_en = 1'b0;
    #1 rst_n = 1'b0;
    tick(3);
    chk1("reset_s_p2", g_inst[0].s_o, 1'b0);
    chk1("reset_r_p2", g_inst[0].r_o, 1'b1);
    check("reset_state_p2", g_inst[0].st_o, 2'b00);
    chk1("reset_s_p4", g_inst[1].s_o, 1'b0);
    chk1("reset_r_p4", g_inst[1].r_o, 1'b1);
    check("reset_state_p4", g_inst[1].st_o, 2'b00);

    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(2);
    chk1("post_reset_r_hold", g_inst[0].r_o, 1'b1);
    tick(1);
    chk1("post_reset_r_drop", g_inst[0].r_o, 1'b0);
    tick(2);
    chk1("post_reset_r_drop_p4", g_inst[1].r_o, 1'b0);

    // bounce shorter than the debounce window
    startn = 1'b0; tick(1);
    startn = 1'b1; tick(1);
    startn = 1'b0; tick(1);
    startn = 1'b1; tick(12);
    chk1("bounce_s", g_inst[0].s_o, 1'b0);
    check("bounce_state", g_inst[0].st_o, 2'b00);

    // clean press: s on the 7th edge counting the first low sample
    startn = 1'b0;
    tick(6);
    chk1("press_s_early", g_inst[0].s_o, 1'b0);
    tick(1);
    chk1("press_s_rise", g_inst[0].s_o, 1'b1);
    check("press_state", g_inst[0].st_o, 2'b01);
    tick(1);
    chk1("press_s_hold", g_inst[0].s_o, 1'b1);
    tick(1);
    chk1("press_s_end", g_inst[0].s_o, 1'b0);
    startn = 1'b1;
    tick(8);

    // door opens while cooking
    door_closed = 1'b0;
    tick(2);
    chk1("door_r", g_inst[0].r_o, 1'b1);
    chk1("door_s", g_inst[0].s_o, 1'b0);
    tick(1);
    check("door_state", g_inst[0].st_o, 2'b10);
    tick(6);
    chk1("door_r_held", g_inst[1].r_o, 1'b1);
    door_closed = 1'b1;
    tick(2);
    chk1("door_close_r", g_inst[0].r_o, 1'b0);
    startn = 1'b0;
    tick(7);
    chk1("resume_s", g_inst[0].s_o, 1'b1);
    check("resume_state", g_inst[0].st_o, 2'b01);
    startn = 1'b1;
    tick(8);

    // timer_done with clear: one r pulse, back to IDLE
    timer_done = 1'b1;
    clearn = 1'b0;
    tick(1);
    chk1("done_r1", g_inst[0].r_o, 1'b1);
    check("done_state", g_inst[0].st_o, 2'b00);
    tick(1);
    chk1("done_r2", g_inst[0].r_o, 1'b1);
    tick(1);
    chk1("done_r_end", g_inst[0].r_o, 1'b0);
    tick(6);
    clearn = 1'b1;
    tick(8);
    startn = 1'b0;
    tick(8);
    chk1("start_while_done_s", g_inst[0].s_o, 1'b0);
    check("start_while_done_state", g_inst[0].st_o, 2'b00);
    startn = 1'b1;
    timer_done = 1'b0;
    tick(8);

    // stop lands inside the 4-cycle s pulse
    startn = 1'b0;
    tick(2);
    stopn = 1'b0;
    tick(6);
    chk1("stop_mid_s_before", g_inst[1].s_o, 1'b1);
    chk1("stop_mid_r_before", g_inst[1].r_o, 1'b0);
    tick(1);
    chk1("stop_mid_s_after", g_inst[1].s_o, 1'b0);
    chk1("stop_mid_r_after", g_inst[1].r_o, 1'b1);
    check("stop_mid_state", g_inst[1].st_o, 2'b10);
    startn = 1'b1;
    stopn = 1'b1;
    tick(8);

    // asynchronous reset in the middle of an s pulse
    startn = 1'b0;
    tick(7);
    chk1("pre_async_s", g_inst[1].s_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async_s_p4", g_inst[1].s_o, 1'b0);
    chk1("async_r_p4", g_inst[1].r_o, 1'b1);
    check("async_state_p4", g_inst[1].st_o, 2'b00);
    chk1("async_r_p2", g_inst[0].r_o, 1'b1);
    startn = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
